// File: rtl/gf503_mul_stage.sv
// ============================================================================
//  Module   : gf503_mul_stage
//  Brief    : GF(503) shift-add multiplier with a single 17-bit fold, feeding
//             the Barrett-503 reducer. Optional macro GF503_MUL_RANGE_CHECK_EN
//             adds operand range correction and a sticky range_err flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gf503_mul_stage #(
    parameter int P      = 503,
    parameter int OP_W   = 9,
    parameter int OUT_W  = 17,
    parameter int FOLD_K = 128768
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  prod_out,
    output logic              range_err
);

    localparam int ACC_W = 2 * OP_W;
    localparam int CNT_W = $clog2(OP_W);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(OP_W - 1);
    localparam logic [ACC_W-1:0] C_FOLD_K   = ACC_W'(FOLD_K);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     a_q, a_d;
    logic [OP_W-1:0]     b_q, b_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0]    prod_q, prod_d;
    logic                vld_q, vld_d;

    logic [OP_W-1:0]     w_a_cap;
    logic [OP_W-1:0]     w_b_cap;
    logic [ACC_W-1:0]    w_addend;
    logic [ACC_W-1:0]    w_fold_sub;
    logic                w_accept;

    assign w_accept = (state_q == S_IDLE) && in_valid;

`ifdef GF503_MUL_RANGE_CHECK_EN
    localparam logic [OP_W-1:0] C_P = OP_W'(P);

    logic w_a_big;
    logic w_b_big;
    logic err_q;

    assign w_a_big = (op_a >= C_P);
    assign w_b_big = (op_b >= C_P);
    // One conditional subtract suffices: 2*P exceeds the 9-bit input range.
    assign w_a_cap = w_a_big ? (op_a - C_P) : op_a;
    assign w_b_cap = w_b_big ? (op_b - C_P) : op_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (w_accept && (w_a_big || w_b_big)) begin
            err_q <= 1'b1;
        end
    end

    assign range_err = err_q;
`else
    assign w_a_cap   = op_a;
    assign w_b_cap   = op_b;
    assign range_err = 1'b0;
`endif

    assign w_addend   = ACC_W'(a_q) << cnt_q;
    assign w_fold_sub = acc_q - C_FOLD_K;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        vld_d   = vld_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = w_a_cap;
                    b_d     = w_b_cap;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (b_q[cnt_q]) begin
                    acc_d = acc_q + w_addend;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_CNT_LAST) begin
                    state_d = S_FOLD;
                end
            end
            S_FOLD: begin
                // Products of in-range operands never exceed 2*FOLD_K, so a
                // single subtract lands below 2^OUT_W.
                if (|acc_q[ACC_W-1:OUT_W]) begin
                    prod_d = w_fold_sub[OUT_W-1:0];
                end else begin
                    prod_d = acc_q[OUT_W-1:0];
                end
                vld_d   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            vld_q   <= vld_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = vld_q;
    assign prod_out  = prod_q;

endmodule

`default_nettype wire
